// File: rtl/display_page_select_pkg.sv
// Shared definitions for the debug display page selector.
// Holds the page encodings and the default debounce interval.
// No logic lives here. Both the top and its sub-module import it.
package display_page_select_pkg;

    // Page index -> value shown on the 8-digit display
    typedef enum logic [1:0] {
        PAGE_PC    = 2'd0,  // live program counter
        PAGE_INSTR = 2'd1,  // live instruction word
        PAGE_WB    = 2'd2,  // last captured writeback data
        PAGE_WBCNT = 2'd3   // number of writebacks seen
    } page_e;

    // 10 ms of stable level at 100 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/display_page_select_button_debounce.sv
// Purpose: synchronize, debounce and rising-edge detect one raw pushbutton.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable samples, then a 1-cycle Pulse.
// Backpressure: none; Pulse is a fire-and-forget strobe.
// Ports: Clk, Rst_n (async active-low), BtnRaw (asynchronous input), Pulse (one cycle per press).
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic BtnRaw,
    output logic Pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0;
    logic             sync1;
    logic             level;
    logic             levelQ;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            level  <= 1'b0;
            levelQ <= 1'b0;
            cnt    <= '0;
        end else begin
            sync0  <= BtnRaw;
            sync1  <= sync0;
            levelQ <= level;
            // cnt counts consecutive samples that disagree with the accepted
            // level; a single agreeing sample restarts the interval.
            if (sync1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // level and levelQ both reset to 0, so a button held through reset
    // cannot produce a pulse before a full debounce interval.
    assign Pulse = level & ~levelQ;

endmodule

// File: rtl/display_page_select.sv
// Purpose: pick PC / instruction / last writeback / writeback count for the debug display.
// Latency: 1 cycle from source or Page change to NumberA/NumberB (while not held).
// Backpressure: none; WBValid is always accepted, Held only freezes the outputs.
// Ports: Clk, Rst_n, BtnNext/BtnHold (raw buttons), PC_in, Instr_in, WBData_in, WBValid,
//        NumberA (low half), NumberB (high half), Page, Held.
module display_page_select
    import display_page_select_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int NUM_WIDTH       = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 BtnNext,
    input  logic                 BtnHold,
    input  logic [31:0]          PC_in,
    input  logic [31:0]          Instr_in,
    input  logic [31:0]          WBData_in,
    input  logic                 WBValid,
    output logic [NUM_WIDTH-1:0] NumberA,
    output logic [NUM_WIDTH-1:0] NumberB,
    output logic [1:0]           Page,
    output logic                 Held
);

    logic        nextPulse;
    logic        holdPulse;
    page_e       pageQ;
    logic        heldQ;
    logic [31:0] wbLast;
    logic [31:0] wbCount;
    logic [31:0] selVal;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .BtnRaw (BtnNext),
        .Pulse  (nextPulse)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hold (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .BtnRaw (BtnHold),
        .Pulse  (holdPulse)
    );

    // Selection uses the registered (pre-update) page and writeback state,
    // so a same-cycle button pulse or WBValid shows up one edge later.
    always_comb begin
        selVal = PC_in;
        case (pageQ)
            PAGE_PC:    selVal = PC_in;
            PAGE_INSTR: selVal = Instr_in;
            PAGE_WB:    selVal = wbLast;
            PAGE_WBCNT: selVal = wbCount;
            default:    selVal = PC_in;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pageQ   <= PAGE_PC;
            heldQ   <= 1'b0;
            wbLast  <= '0;
            wbCount <= '0;
            NumberA <= '0;
            NumberB <= '0;
        end else begin
            if (nextPulse) begin
                pageQ <= page_e'(pageQ + 2'd1);
            end
            if (holdPulse) begin
                heldQ <= ~heldQ;
            end
            // Writeback capture keeps running while the display is frozen.
            if (WBValid) begin
                wbLast  <= WBData_in;
                wbCount <= wbCount + 32'd1;
            end
            if (!heldQ) begin
                NumberA <= NUM_WIDTH'(selVal[15:0]);
                NumberB <= NUM_WIDTH'(selVal[31:16]);
            end
        end
    end

    assign Page = pageQ;
    assign Held = heldQ;

endmodule

// File: tb/tb_display_page_select.sv
module tb_display_page_select;

    localparam int DB = 4;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        BtnNext;
    logic        BtnHold;
    logic [31:0] PC_in;
    logic [31:0] Instr_in;
    logic [31:0] WBData_in;
    logic        WBValid;
    logic [15:0] NumberA;
    logic [15:0] NumberB;
    logic [1:0]  Page;
    logic        Held;

    int nChecks = 0;
    int nPass   = 0;

    // Reference model: page/hold state and writeback bookkeeping
    int          mPage;
    bit          mHeld;
    logic [31:0] mWbLast;
    logic [31:0] mWbCount;
    logic [31:0] mOut;

    display_page_select #(.DEBOUNCE_CYCLES(DB), .NUM_WIDTH(16)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .BtnNext   (BtnNext),
        .BtnHold   (BtnHold),
        .PC_in     (PC_in),
        .Instr_in  (Instr_in),
        .WBData_in (WBData_in),
        .WBValid   (WBValid),
        .NumberA   (NumberA),
        .NumberB   (NumberB),
        .Page      (Page),
        .Held      (Held)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] model_src();
        logic [31:0] srcs [4];
        srcs[0] = PC_in;
        srcs[1] = Instr_in;
        srcs[2] = mWbLast;
        srcs[3] = mWbCount;
        return srcs[mPage];
    endfunction

    task automatic model_reset();
        mPage    = 0;
        mHeld    = 0;
        mWbLast  = '0;
        mWbCount = '0;
        mOut     = '0;
    endtask

    // Clean press: high long enough for sync + debounce, then low just as long
    task automatic press(input bit isHold);
        @(negedge Clk);
        if (isHold) BtnHold = 1'b1; else BtnNext = 1'b1;
        repeat (DB + 6) @(negedge Clk);
        BtnHold = 1'b0;
        BtnNext = 1'b0;
        repeat (DB + 6) @(negedge Clk);
        if (isHold) mHeld = !mHeld;
        else        mPage = (mPage + 1) % 4;
        if (!mHeld) mOut = model_src();
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        bit seen;
        Rst_n = 1'b0;
        BtnNext = 1'b1;
        repeat (3) @(negedge Clk);
        nChecks++;
        if ({NumberB, NumberA, Page, Held} !== 35'd0)
            $display("FAIL reset_state: got %h want 0", {NumberB, NumberA, Page, Held});
        else nPass++;
        Rst_n = 1'b1;
        model_reset();
        // 2 sync cycles + DB stable samples: no page change may happen yet
        repeat (2 + DB) @(posedge Clk);
        #1;
        nChecks++;
        if (Page !== 2'd0) $display("FAIL reset_early_pulse: Page %0d want 0", Page);
        else nPass++;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(posedge Clk); #1;
            if (Page === 2'd1) seen = 1;
        end
        nChecks++;
        if (Page !== 2'd1) $display("FAIL reset_held_accept: Page %0d want 1", Page);
        else nPass++;
        repeat (10) @(negedge Clk);
        nChecks++;
        if (Page !== 2'd1) $display("FAIL reset_single_pulse: Page %0d want 1", Page);
        else nPass++;
        BtnNext = 1'b0;
        repeat (DB + 6) @(negedge Clk);
        mPage = 1;
        mOut  = model_src();
    endtask

    task automatic test_bounce();
        @(negedge Clk);
        for (int i = 0; i < 20; i++) begin
            BtnNext = ((i / 2) % 2 == 0);
            @(negedge Clk);
        end
        BtnNext = 1'b1;
        repeat (10) @(negedge Clk);
        BtnNext = 1'b0;
        repeat (DB + 6) @(negedge Clk);
        mPage = (mPage + 1) % 4;
        mOut  = model_src();
        nChecks++;
        if (Page !== 2'(mPage)) $display("FAIL bounce_one_increment: Page %0d want %0d", Page, mPage);
        else nPass++;
    endtask

    task automatic test_clean_presses();
        int expSeq [4] = '{1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            press(1'b0);
            nChecks++;
            if (Page !== 2'(expSeq[i])) $display("FAIL clean_press_%0d: Page %0d want %0d", i, Page, expSeq[i]);
            else nPass++;
        end
        @(negedge Clk);
        PC_in = 32'h12345678;
        @(posedge Clk); #1;
        nChecks++;
        if (NumberB !== 16'h1234 || NumberA !== 16'h5678)
            $display("FAIL page0_pc: got %h_%h want 1234_5678", NumberB, NumberA);
        else nPass++;
        mOut = 32'h12345678;
    endtask

    task automatic test_hold();
        logic [31:0] frozen;
        bit released;
        Instr_in = $urandom;
        press(1'b1);
        nChecks++;
        if (Held !== 1'b1) $display("FAIL hold_on: Held %b want 1", Held);
        else nPass++;
        frozen = mOut;
        @(negedge Clk);
        PC_in = 32'hDEADBEEF;
        press(1'b0);
        nChecks++;
        if ({NumberB, NumberA} !== frozen || Page !== 2'd1)
            $display("FAIL hold_frozen: got %h page %0d want %h page 1", {NumberB, NumberA}, Page, frozen);
        else nPass++;
        @(negedge Clk);
        BtnHold = 1'b1;
        released = 0;
        for (int i = 0; i < 3 * DB + 10 && !released; i++) begin
            @(posedge Clk); #1;
            if (Held === 1'b0) released = 1;
        end
        nChecks++;
        if (!released || {NumberB, NumberA} !== frozen)
            $display("FAIL hold_release_edge: held %b out %h want 0 / %h", Held, {NumberB, NumberA}, frozen);
        else nPass++;
        @(posedge Clk); #1;
        nChecks++;
        if ({NumberB, NumberA} !== Instr_in)
            $display("FAIL hold_release_instr: got %h want %h", {NumberB, NumberA}, Instr_in);
        else nPass++;
        @(negedge Clk);
        BtnHold = 1'b0;
        repeat (DB + 6) @(negedge Clk);
        mHeld = 0;
        mOut  = model_src();
    endtask

    task automatic run_data(input int n, input int tag);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            PC_in     = $urandom;
            Instr_in  = $urandom;
            WBData_in = $urandom;
            WBValid   = 1'($urandom_range(0, 1));
            if (!mHeld) mOut = model_src();
            if (WBValid) begin
                mWbLast  = WBData_in;
                mWbCount = mWbCount + 32'd1;
            end
            @(posedge Clk); #1;
            if ({NumberB, NumberA} !== mOut) begin
                if (bad < 3)
                    $display("FAIL data_r%0d_c%0d: got %h want %h", tag, i, {NumberB, NumberA}, mOut);
                bad++;
            end
        end
        @(negedge Clk);
        WBValid = 1'b0;
        if (!mHeld) mOut = model_src();
        nChecks++;
        if (bad == 0) nPass++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            press((r == 2 || r == 4) ? 1'b1 : 1'b0);
            nChecks++;
            if (Page !== 2'(mPage) || Held !== mHeld)
                $display("FAIL rand_press_%0d: page %0d held %b want %0d %b", r, Page, Held, mPage, mHeld);
            else nPass++;
            run_data(30, r);
        end
    endtask

    task automatic test_reset_mid();
        if (!mHeld) press(1'b1);
        @(negedge Clk);
        BtnNext = 1'b1;
        repeat (3) @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        nChecks++;
        if ({NumberB, NumberA, Page, Held} !== 35'd0)
            $display("FAIL reset_async: got %h want 0", {NumberB, NumberA, Page, Held});
        else nPass++;
        BtnNext = 1'b0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
        repeat (DB + 6) @(negedge Clk);
        mOut = model_src();
    endtask

    task automatic test_wrap();
        while (mPage != 3) press(1'b0);
        @(negedge Clk);
        force dut.wbCount = 32'hFFFFFFFF;
        #1;
        release dut.wbCount;
        mWbCount = 32'hFFFFFFFF;
        @(posedge Clk); #1;
        nChecks++;
        if ({NumberB, NumberA} !== 32'hFFFFFFFF)
            $display("FAIL wrap_preset: got %h want ffffffff", {NumberB, NumberA});
        else nPass++;
        @(negedge Clk);
        WBData_in = $urandom;
        WBValid   = 1'b1;
        @(posedge Clk); #1;
        nChecks++;
        if ({NumberB, NumberA} !== 32'hFFFFFFFF)
            $display("FAIL wrap_same_cycle: got %h want ffffffff", {NumberB, NumberA});
        else nPass++;
        @(negedge Clk);
        WBValid = 1'b0;
        @(posedge Clk); #1;
        nChecks++;
        if ({NumberB, NumberA} !== 32'h0)
            $display("FAIL wrap_zero: got %h want 00000000", {NumberB, NumberA});
        else nPass++;
    endtask

    initial begin
        Rst_n     = 1'b0;
        BtnNext   = 1'b0;
        BtnHold   = 1'b0;
        PC_in     = '0;
        Instr_in  = '0;
        WBData_in = '0;
        WBValid   = 1'b0;
        model_reset();
        test_reset();
        test_bounce();
        test_clean_presses();
        test_hold();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
